// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the post-Decode control pipeline: default geometry,
// control-bundle field positions and the per-stage update policy.
package ctrl_pipe_pkg;

  localparam int CP_W         = 16;
  localparam int CP_NSTG      = 3;
  localparam int CP_MEM_STG   = 1;
  localparam int CP_MEMWR_BIT = 1;

  // Field positions inside the generic control bundle
  localparam int MEMTOREG_BIT = 0;
  localparam int MEMWRITE_BIT = 1;
  localparam int ALUSRC_BIT   = 2;
  localparam int REGDST_BIT   = 3;
  localparam int REGWRITE_BIT = 4;
  localparam int CP0WE_BIT    = 5;
  localparam int MEMEN_BIT    = 6;
  localparam int TLB_TYPE_LSB = 7;
  localparam int TLB_TYPE_W   = 3;
  localparam int HILO_WE_LSB  = 10;
  localparam int HILO_WE_W    = 2;

  // Layout of one stage register: {bundle, valid, ll, sc}
  localparam int SC_POS     = 0;
  localparam int LL_POS     = 1;
  localparam int VALID_POS  = 2;
  localparam int BUNDLE_LSB = 3;

  typedef enum logic [1:0] {
    ST_BUBBLE,
    ST_HOLD,
    ST_LOAD
  } stageAct_t;

  // Flush beats hold; an upstream stall must inject a bubble so the
  // instruction that is still held upstream is not duplicated here.
  function automatic stageAct_t selectAct(input logic flush, input logic stall,
                                          input logic upStall);
    if (flush)   return ST_BUBBLE;
    if (stall)   return ST_HOLD;
    if (upStall) return ST_BUBBLE;
    return ST_LOAD;
  endfunction

endpackage

// File: rtl/ctrl_pipe_stage.sv
// One pipeline register with flush/stall/bubble control; carries the bundle
// plus valid, LL and SC flags as a single vector.
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int WIDTH = CP_W + 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             stall,
  input  logic             upStall,
  input  logic [WIDTH-1:0] dIn,
  output logic [WIDTH-1:0] q
);

  stageAct_t        act;
  logic [WIDTH-1:0] qNext;

  always_comb begin
    // NOTE: qNext gets a default before the case so every path assigns it and no latch is inferred.
    qNext = q;
    act   = selectAct(flush, stall, upStall);
    unique case (act)
      ST_BUBBLE: qNext = '0;
      ST_HOLD:   qNext = q;
      default:   qNext = dIn;
    endcase
  end

  // NOTE: non-blocking update so each stage samples its neighbour's pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= qNext;
  end

endmodule

// File: rtl/ctrl_pipe_n.sv
// Control-signal pipeline from Decode through NSTG stages; owns the LL/SC
// link bit and gates the SC memory write at the memory stage.
module ctrl_pipe_n
  import ctrl_pipe_pkg::*;
#(
  parameter int W         = CP_W,
  parameter int NSTG      = CP_NSTG,
  parameter int MEM_STG   = CP_MEM_STG,
  parameter int MEMWR_BIT = CP_MEMWR_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      ctrl_d,
  input  logic              valid_d,
  input  logic              ll_d,
  input  logic              sc_d,
  input  logic              stall_d,
  input  logic [NSTG-1:0]   stall,
  input  logic [NSTG-1:0]   flush,
  input  logic              llbit_clr,
  output logic [NSTG*W-1:0] ctrl_o,
  output logic [NSTG-1:0]   valid_o,
  output logic [NSTG-1:0]   ll_o,
  output logic [NSTG-1:0]   sc_o,
  output logic              sc_ok_m,
  output logic              llbit_o
);

  localparam int SW = W + 3;

  logic [SW-1:0] stageD [NSTG];
  logic [SW-1:0] stageQ [NSTG];
  logic          upStall[NSTG];

  logic          commit;
  logic          llCommit;
  logic          llbit;
  logic          llbitEff;
  logic [W-1:0]  memBundle;

  for (genvar i = 0; i < NSTG; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign stageD[i]  = {ctrl_d, valid_d, ll_d, sc_d};
      assign upStall[i] = stall_d;
    end else begin : g_body
      assign stageD[i]  = stageQ[i-1];
      assign upStall[i] = stall[i-1];
    end

    ctrl_pipe_stage #(
      .WIDTH(SW)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush[i]),
      .stall  (stall[i]),
      .upStall(upStall[i]),
      .dIn    (stageD[i]),
      .q      (stageQ[i])
    );

    assign valid_o[i] = stageQ[i][VALID_POS];
    assign ll_o[i]    = stageQ[i][LL_POS];
    assign sc_o[i]    = stageQ[i][SC_POS];

    if (i == MEM_STG) begin : g_mem_out
      assign ctrl_o[i*W +: W] = memBundle;
    end else begin : g_plain_out
      assign ctrl_o[i*W +: W] = stageQ[i][SW-1:BUNDLE_LSB];
    end
  end

  assign commit   = valid_o[NSTG-1] & ~stall[NSTG-1];
  assign llCommit = commit & ll_o[NSTG-1];

  // An LL retiring this cycle already counts for an SC sitting in the memory stage.
  assign llbitEff = (llbit | llCommit) & ~llbit_clr;
  assign sc_ok_m  = sc_o[MEM_STG] & valid_o[MEM_STG] & llbitEff;

  // Only the outgoing copy is gated; the stored bundle keeps its memwrite.
  always_comb begin
    memBundle = stageQ[MEM_STG][SW-1:BUNDLE_LSB];
    if (sc_o[MEM_STG]) memBundle[MEMWR_BIT] = memBundle[MEMWR_BIT] & llbitEff;
  end

  always_ff @(posedge clk) begin
    if (rst)            llbit <= 1'b0;
    else if (llbit_clr) llbit <= 1'b0;
    else if (llCommit)  llbit <= 1'b1;
  end

  assign llbit_o = llbit;

endmodule

// File: doc/ctrl_pipe_n.md
Name: ctrl_pipe_n

Overview:
- Parametrised control-signal pipeline for the MIPS core.
- Carries a decoded control bundle from Decode through NSTG downstream stages. Default NSTG=3 covers Execute, Memory and Writeback.
- Each stage has its own stall and flush, a per-stage valid bit, and automatic bubble insertion when the upstream stage stalls.
- Owns the LL/SC link bit. The link bit gates the store-conditional memory write in the memory stage and bypasses it from an LL committing in the same cycle.

Parameters:
- W, 16: width of the generic control bundle per stage.
- NSTG, 3: number of pipeline stages after Decode; minimum 2.
- MEM_STG, 1: index of the memory stage (0-based after Decode); must be < NSTG-1.
- MEMWR_BIT, 1: bit position of memwrite inside the bundle.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- ctrl_d, in, W: decoded control bundle from Decode.
- valid_d, in, 1: Decode holds a real instruction.
- ll_d, in, 1: Decode instruction is LL.
- sc_d, in, 1: Decode instruction is SC.
- stall_d, in, 1: Decode is stalled; nothing leaves it this cycle.
- stall, in, NSTG: per-stage hold; bit i is stage i.
- flush, in, NSTG: per-stage kill; bit i is stage i.
- llbit_clr, in, 1: clear link bit (exception/ERET).
- ctrl_o, out, NSTG*W: stage i bundle at bits [i*W +: W], with the memwrite gating applied at MEM_STG.
- valid_o, out, NSTG: per-stage valid.
- ll_o, out, NSTG: per-stage LL flag.
- sc_o, out, NSTG: per-stage SC flag.
- sc_ok_m, out, 1: SC in the memory stage will succeed.
- llbit_o, out, 1: registered link bit.

Behaviour:
- Reset (rst=1 at clk edge): every stage bundle, valid, ll and sc is 0, and llbit is 0. All outputs are therefore 0 the cycle after reset. Reset mid-operation discards all in-flight instructions.
- Stage i register update, in priority order:
  1. flush[i] -> bubble (bundle=0, valid=0, ll=0, sc=0).
  2. stall[i] -> hold.
  3. Upstream stalled -> bubble. Upstream is stall_d for i=0, stall[i-1] otherwise. This prevents an instruction being duplicated.
  4. Otherwise load from upstream. Stage 0 loads {ctrl_d, valid_d, ll_d, sc_d}.
- Flush beats stall when both are set for the same stage.
- Latency is one cycle per stage: an instruction in Decode at cycle t with no stalls is in stage i at cycle t+1+i.
- Bundles with valid=0 are passed through as-is. The block does not mask the bundle by valid, except through the bubble rule.
- Commit is defined as valid_o[NSTG-1] & ~stall[NSTG-1].
- ll_commit = commit & ll_o[NSTG-1].
- Link bit next-state:
  - llbit_clr -> 0; clear beats set in the same cycle.
  - ll_commit -> 1.
  - Otherwise hold.
- SC in the memory stage sees the link bit with bypass: llbit_eff = (llbit | ll_commit) & ~llbit_clr. This is combinational within the same cycle.
- sc_ok_m = sc_o[MEM_STG] & valid_o[MEM_STG] & llbit_eff.
- memwrite gating in ctrl_o:
  - At stage MEM_STG, if sc_o[MEM_STG] is 1, bit MEMWR_BIT is forced to registered_memwrite & llbit_eff.
  - Bit MEMWR_BIT is otherwise unchanged.
  - Gating is output-only; the stored bundle is never modified.
  - No other stage is gated.
- SC does not clear the link bit.
- Only the register file sees the SC result, through sc_ok_m forwarded by the datapath.

Decomposition:
- Shared package ctrl_pipe_pkg holds:
  - default W, NSTG, MEM_STG, MEMWR_BIT;
  - the bundle field-index constants (memtoreg, memwrite, alusrc, regdst, regwrite, cp0we, memen, tlb_type[2:0], hilo_we[1:0]).
- One natural sub-module: ctrl_pipe_stage. It is a single flush/stall/bubble register of width W+3, instantiated NSTG times in a generate loop.
- The link-bit logic and the SC gating stay in the top-level module.

Test Plan:
- Free-flow: valid_d=1 with ctrl_d=16'h00A5 at cycle 0, no stalls -> ctrl_o stage0=00A5 at cycle 1, stage1=00A5 at cycle 2, stage2=00A5 at cycle 3. The bubble following it has valid_o=0.
- Stall bubble: stall[0]=1 for 2 cycles while holding 16'h1234 -> stage0 holds 1234, and stage1 receives two bubbles (valid 0, bundle 0). After release, 1234 appears exactly once in stage1.
- Flush priority: flush[1]=1 and stall[1]=1 in the same cycle with stage1=16'hFFFF -> next cycle stage1 bundle=0 and valid=0.
- LL/SC success with bypass: LL with no stalls, SC one cycle behind it carrying memwrite=1. At the cycle LL commits in stage2, SC sits in stage1 -> sc_ok_m=1 and memwrite in stage1 output=1. llbit_o=1 on the next cycle.
- SC failure and clear: llbit_o=1, then llbit_clr=1 for one cycle, then SC reaches MEM_STG -> sc_ok_m=0 and stage1 memwrite output=0, while the stored bundle still has memwrite=1. With llbit_clr=1 and ll_commit=1 in the same cycle -> llbit_o=0.
- Reset mid-flight: with all stages valid and llbit=1, assert rst for one cycle -> next cycle all ctrl_o, valid_o, ll_o, sc_o, llbit_o and sc_ok_m are 0.
